// File: rtl/exam1_a_pkg.sv
// Shared constants for the exam1_a registered mini-ALU.
// Build option: EXAM1_A_SUB_EN turns opcode 2'b10 into a signed subtract.
package exam1_a_pkg;

  localparam int WIDTH = 8;

  localparam logic [1:0] OP_MUL     = 2'b00;
  localparam logic [1:0] OP_APPEND  = 2'b01;
  localparam logic [1:0] OP_SUB_DEF = 2'b10;
  localparam logic [1:0] OP_PLUS    = 2'b11;

endpackage

// File: rtl/exam1_a_mul.sv
// Combinational signed WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
// The operand MSB carries negative weight, so its partial product is subtracted.
module exam1_a_mul #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0]   a_i,
  input  logic signed [WIDTH-1:0]   b_i,
  output logic signed [2*WIDTH-1:0] p_o
);

  localparam int RW = 2 * WIDTH;

  logic [RW-1:0] a_ext;
  logic [RW-1:0] pp  [WIDTH];
  logic [RW-1:0] acc [WIDTH+1];

  assign a_ext  = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_pos_pp
      assign pp[gi] = b_i[gi] ? (a_ext << gi) : '0;
    end
  endgenerate

  // Two's-complement negation of the MSB-weighted row.
  assign pp[WIDTH-1] = b_i[WIDTH-1] ? (~(a_ext << (WIDTH - 1)) + RW'(1)) : '0;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_acc
      assign acc[gi+1] = acc[gi] + pp[gi];
    end
  endgenerate

  assign p_o = acc[WIDTH];

endmodule

// File: rtl/exam1_a.sv
// Registered signed mini-ALU: MUL / APPEND / PLUS / DEFAULT, one op per cycle, 1-cycle latency.
// Build option: EXAM1_A_SUB_EN makes opcode 2'b10 compute A - B instead of 0.
module exam1_a #(
  parameter int WIDTH = exam1_a_pkg::WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [WIDTH-1:0]   A,
  input  logic signed [WIDTH-1:0]   B,
  input  logic        [1:0]         ctrl,
  output logic signed [2*WIDTH-1:0] out
);

  import exam1_a_pkg::*;

  localparam int RW = 2 * WIDTH;

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic [RW-1:0] mul_res;
  logic [RW-1:0] app_res;
  logic [RW-1:0] plus_res;
  logic [RW-1:0] def_res;
  logic [RW-1:0] out_d;
  logic [RW-1:0] out_q;

  assign a_ext = {{WIDTH{A[WIDTH-1]}}, A};
  assign b_ext = {{WIDTH{B[WIDTH-1]}}, B};

  exam1_a_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .a_i (A),
    .b_i (B),
    .p_o (mul_res)
  );

  assign app_res  = {A, B};
  assign plus_res = a_ext + b_ext;

`ifdef EXAM1_A_SUB_EN
  assign def_res = a_ext - b_ext;
`else
  assign def_res = '0;
`endif

  // Any opcode that matches nothing (including X/Z) falls to the default result.
  always_comb begin
    out_d = def_res;
    case (ctrl)
      OP_MUL:     out_d = mul_res;
      OP_APPEND:  out_d = app_res;
      OP_PLUS:    out_d = plus_res;
      OP_SUB_DEF: out_d = def_res;
      default:    out_d = def_res;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_exam1_a.sv
// Directed and randomized self-checking bench for the exam1_a mini-ALU.
// Honors EXAM1_A_SUB_EN for the opcode 2'b10 expectations.
module tb_exam1_a;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  A = 8'd0;
  logic [7:0]  B = 8'd0;
  logic [1:0]  ctrl = 2'b00;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  exam1_a dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .ctrl (ctrl),
    .out  (out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] c);
    logic signed [15:0] ae;
    logic signed [15:0] be;
    logic signed [15:0] r;
    ae = {{8{a[7]}}, a};
    be = {{8{b[7]}}, b};
    case (c)
      2'b00:   r = ae * be;
      2'b01:   r = {a, b};
      2'b11:   r = ae + be;
`ifdef EXAM1_A_SUB_EN
      default: r = ae - be;
`else
      default: r = 16'sd0;
`endif
    endcase
    return r;
  endfunction

  // Drive one vector between edges, then let it register and settle.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c);
    @(negedge clk);
    A = a;
    B = b;
    ctrl = c;
    @(posedge clk);
    #1;
    $display("txn A=%02h B=%02h ctrl=%02b -> out=%04h", a, b, c, out);
  endtask

  task automatic test_reset();
    A = 'z;
    B = 'z;
    ctrl = 'z;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: out=%04h expected 0000", out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: out=%04h expected 0000", out);
    end
    @(negedge clk);
    A = 8'd3;
    B = 8'd4;
    ctrl = 2'b11;
    rst = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: out=%04h expected 0000", out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0007) begin
      errors++;
      $display("FAIL reset_first_op: out=%04h expected 0007", out);
    end
  endtask

  task automatic test_mul();
    apply(8'd23, -8'sd45, 2'b00);
    checks++;
    if (out !== 16'hFBF5) begin
      errors++;
      $display("FAIL mul_23x-45: out=%04h expected FBF5", out);
    end
    apply(8'h80, 8'h80, 2'b00);
    checks++;
    if (out !== 16'h4000) begin
      errors++;
      $display("FAIL mul_-128x-128: out=%04h expected 4000", out);
    end
    apply(8'd127, 8'h80, 2'b00);
    checks++;
    if (out !== 16'hC080) begin
      errors++;
      $display("FAIL mul_127x-128: out=%04h expected C080", out);
    end
  endtask

  task automatic test_append();
    apply(8'h17, 8'hD3, 2'b01);
    checks++;
    if (out !== 16'h17D3) begin
      errors++;
      $display("FAIL append_17D3: out=%04h expected 17D3", out);
    end
    apply(8'hFF, 8'h00, 2'b01);
    checks++;
    if (out !== 16'hFF00) begin
      errors++;
      $display("FAIL append_FF00: out=%04h expected FF00", out);
    end
  endtask

  task automatic test_plus();
    apply(8'd127, 8'd127, 2'b11);
    checks++;
    if (out !== 16'h00FE) begin
      errors++;
      $display("FAIL plus_127+127: out=%04h expected 00FE", out);
    end
    apply(8'h80, 8'h80, 2'b11);
    checks++;
    if (out !== 16'hFF00) begin
      errors++;
      $display("FAIL plus_-128+-128: out=%04h expected FF00", out);
    end
    apply(8'd5, -8'sd7, 2'b11);
    checks++;
    if (out !== 16'hFFFE) begin
      errors++;
      $display("FAIL plus_5+-7: out=%04h expected FFFE", out);
    end
  endtask

  task automatic test_default();
    logic [15:0] exp1;
    logic [15:0] exp2;
`ifdef EXAM1_A_SUB_EN
    exp1 = 16'h0007;
    exp2 = 16'hFF01;
`else
    exp1 = 16'h0000;
    exp2 = 16'h0000;
`endif
    apply(8'd10, 8'd3, 2'b10);
    checks++;
    if (out !== exp1) begin
      errors++;
      $display("FAIL default_10_3: out=%04h expected %04h", out, exp1);
    end
    apply(8'h80, 8'd127, 2'b10);
    checks++;
    if (out !== exp2) begin
      errors++;
      $display("FAIL default_-128_127: out=%04h expected %04h", out, exp2);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  c;
    logic [15:0] exp_v;
    bit          have;
    have = 1'b0;
    c = 2'($urandom_range(0, 3));
    exp_v = 16'h0000;
    for (int i = 0; i <= 800; i++) begin
      @(negedge clk);
      if (have) begin
        checks++;
        if (out !== exp_v) begin
          errors++;
          $display("FAIL b2b_%0d: out=%04h expected %04h", i - 1, out, exp_v);
        end
      end
      if (i < 800) begin
        a = 8'($urandom);
        b = 8'($urandom);
        c = c + 2'($urandom_range(1, 3));
        A = a;
        B = b;
        ctrl = c;
        exp_v = model(a, b, c);
        have = 1'b1;
        $display("txn b2b %0d A=%02h B=%02h ctrl=%02b expect=%04h", i, a, b, c, exp_v);
      end
    end
  endtask

  task automatic test_midstream_reset();
    apply(8'd23, -8'sd45, 2'b00);
    checks++;
    if (out !== 16'hFBF5) begin
      errors++;
      $display("FAIL mid_pre: out=%04h expected FBF5", out);
    end
    @(negedge clk);
    A = 8'd127;
    B = 8'd127;
    ctrl = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL mid_async: out=%04h expected 0000", out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h0000) begin
      errors++;
      $display("FAIL mid_discard: out=%04h expected 0000", out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 16'h00FE) begin
      errors++;
      $display("FAIL mid_resume: out=%04h expected 00FE", out);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_append();
    test_plus();
    test_default();
    test_back_to_back();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
